// File: rtl/sn_drain.sv
// sn/i down-drain: load a count, then drain one unit per selector cycle.
// Optional SN_DRAIN_ASSERT_EN adds clocked invariant assertions.
module sn_drain #(
    parameter int W     = 10,
    parameter int LIMIT = 250
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_valid,
    input  logic [W-1:0] load_val,
    output logic         load_ready,
    input  logic         selector,
    output logic [W-1:0] sn,
    output logic [W-1:0] i,
    output logic         busy,
    output logic         done,
    output logic         err
);

    localparam logic [W-1:0] LIM = W'(LIMIT);
    localparam logic [W-1:0] ONE = W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        FIN   = 2'd2
    } state_t;

    state_t       state, state_n;
    logic [W-1:0] sn_n, i_n, tgt, tgt_n;
    logic         err_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            sn    <= '0;
            i     <= '0;
            tgt   <= '0;
            err   <= 1'b0;
        end else begin
            state <= state_n;
            sn    <= sn_n;
            i     <= i_n;
            tgt   <= tgt_n;
            err   <= err_n;
        end
    end

    always_comb begin
        state_n = state;
        sn_n    = sn;
        i_n     = i;
        tgt_n   = tgt;
        err_n   = err;
        unique case (state)
            IDLE: begin
                // Out-of-range loads are consumed but only flag err.
                if (load_valid) begin
                    if (load_val > LIM) begin
                        err_n = 1'b1;
                    end else begin
                        sn_n    = load_val;
                        i_n     = '0;
                        tgt_n   = load_val;
                        state_n = (load_val == '0) ? FIN : DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (selector) begin
                    sn_n = sn - ONE;
                    i_n  = i + ONE;
                    if (sn == ONE) state_n = FIN;
                end
            end
            FIN: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    assign load_ready = (state == IDLE);
    assign busy       = (state == DRAIN);
    assign done       = (state == FIN);

`ifdef SN_DRAIN_ASSERT_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert ((state == IDLE) || (sn + i == tgt))
                else $error("sn + i != tgt");
            assert (i <= LIM)
                else $error("i above limit");
            assert (!((state == DRAIN) && (sn == '0)))
                else $error("drain with sn == 0");
            assert (!done || (sn == '0))
                else $error("done with sn != 0");
        end
    end
`endif

endmodule
